// File: rtl/carbonio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// carbonio_irq_ctrl
//
// Interrupt aggregator for CarbonIO. One-cycle event pulses from peripheral
// sources are latched as pending, gated by a per-source mask and arbitrated
// with fixed priority (lowest index wins). The winner is presented to the CPU
// and moved into service on acknowledge. It is retired by an end-of-interrupt
// strobe carrying the matching ID. Only one interrupt can be in service at a
// time; there is no nesting.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   synchronous active-low reset
//   src_pulse    in   per-source event pulses (one event per high cycle)
//   mask_we      in   mask register write strobe
//   mask_wdata   in   new mask value (1 = enabled)
//   pend_set     in   software trigger, sets pending bits
//   pend_clr     in   write-1-to-clear for pending bits
//   ovf_clr      in   write-1-to-clear for overflow bits
//   irq_ack      in   CPU accepts the presented interrupt
//   eoi          in   end-of-interrupt strobe
//   eoi_id       in   ID of the interrupt being retired
//   mask_q       out  mask register
//   pending_q    out  pending register
//   overflow_q   out  sticky per-source lost-event flags
//   irq_req      out  interrupt presented to the CPU
//   irq_id       out  ID of the presented interrupt (0 when irq_req is low)
//   insvc_valid  out  an interrupt is in service (this is the FSM state)
//   insvc_id     out  ID of the interrupt in service
//
// CPU handshake: irq_req/irq_id act as valid/data and irq_ack as ready. A
// transfer happens only in a cycle where irq_req and irq_ack are both high;
// irq_ack with irq_req low has no effect. irq_req is a function of registered
// state only and never depends on irq_ack in the same cycle. Once a transfer
// happens, irq_req drops until eoi with eoi_id == insvc_id retires the
// interrupt.
// -----------------------------------------------------------------------------
module carbonio_irq_ctrl #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] src_pulse,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   input  logic [NUM_SRC-1:0] pend_set,
   input  logic [NUM_SRC-1:0] pend_clr,
   input  logic [NUM_SRC-1:0] ovf_clr,
   input  logic               irq_ack,
   input  logic               eoi,
   input  logic [ID_W-1:0]    eoi_id,
   output logic [NUM_SRC-1:0] mask_q,
   output logic [NUM_SRC-1:0] pending_q,
   output logic [NUM_SRC-1:0] overflow_q,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   output logic               insvc_valid,
   output logic [ID_W-1:0]    insvc_id
);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_SERVICE = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [ID_W-1:0]    insvc_id_q, insvc_id_d;
   logic [NUM_SRC-1:0] mask_d, pending_d, overflow_d;

   logic [NUM_SRC-1:0] eligible;
   logic               any_eligible;
   logic [ID_W-1:0]    win_id;
   logic               ack_fire;
   logic [NUM_SRC-1:0] ack_vec;

   // Fixed-priority pick: the first eligible bit scanning up from index 0.
   always_comb begin
      any_eligible = 1'b0;
      win_id       = '0;
      eligible     = pending_q & mask_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!any_eligible && eligible[i]) begin
            any_eligible = 1'b1;
            win_id       = ID_W'(i);
         end
      end
   end

   assign irq_req  = any_eligible && (state_q == ST_IDLE);
   assign irq_id   = irq_req ? win_id : '0;
   assign ack_fire = irq_ack && irq_req;

   // One-hot of the source being accepted this cycle (all zero without ack).
   always_comb begin
      ack_vec = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_vec[i] = ack_fire && (irq_id == ID_W'(i));
      end
   end

   // Sets win over clears. An acknowledge consumes the pending event, so a
   // pulse colliding with the ack of the same source is a fresh event rather
   // than a lost one.
   always_comb begin
      mask_d     = mask_we ? mask_wdata : mask_q;
      pending_d  = src_pulse | pend_set | (pending_q & ~(pend_clr | ack_vec));
      overflow_d = (src_pulse & pending_q & ~ack_vec) | (overflow_q & ~ovf_clr);
   end

   always_comb begin
      state_d    = state_q;
      insvc_id_d = insvc_id_q;
      case (state_q)
         ST_IDLE: begin
            if (ack_fire) begin
               state_d    = ST_SERVICE;
               insvc_id_d = irq_id;
            end
         end
         ST_SERVICE: begin
            if (eoi && (eoi_id == insvc_id_q)) begin
               state_d    = ST_IDLE;
               insvc_id_d = '0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            insvc_id_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         insvc_id_q <= '0;
         mask_q     <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
      end else begin
         state_q    <= state_d;
         insvc_id_q <= insvc_id_d;
         mask_q     <= mask_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   assign insvc_valid = (state_q == ST_SERVICE);
   assign insvc_id    = insvc_id_q;

endmodule

// File: tb/tb_carbonio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_carbonio_irq_ctrl
//
// Directed vector bench for carbonio_irq_ctrl (NUM_SRC = 8). Each record holds
// the inputs for one clock cycle and the register/output values expected just
// after that rising edge.
// -----------------------------------------------------------------------------
module tb_carbonio_irq_ctrl;

   typedef struct {
      logic       rst_n;
      logic [7:0] pulse;
      logic       mwe;
      logic [7:0] mwd;
      logic [7:0] pset;
      logic [7:0] pclr;
      logic [7:0] oclr;
      logic       ack;
      logic       eoi;
      logic [2:0] eid;
      logic [7:0] e_mask;
      logic [7:0] e_pend;
      logic [7:0] e_ovf;
      logic       e_req;
      logic [2:0] e_id;
      logic       e_iv;
      logic [2:0] e_iid;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] src_pulse = '0;
   logic       mask_we = 1'b0;
   logic [7:0] mask_wdata = '0;
   logic [7:0] pend_set = '0;
   logic [7:0] pend_clr = '0;
   logic [7:0] ovf_clr = '0;
   logic       irq_ack = 1'b0;
   logic       eoi = 1'b0;
   logic [2:0] eoi_id = '0;
   logic [7:0] mask_q, pending_q, overflow_q;
   logic       irq_req, insvc_valid;
   logic [2:0] irq_id, insvc_id;

   always #5 clk = ~clk;

   carbonio_irq_ctrl #(.NUM_SRC(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .src_pulse   (src_pulse),
      .mask_we     (mask_we),
      .mask_wdata  (mask_wdata),
      .pend_set    (pend_set),
      .pend_clr    (pend_clr),
      .ovf_clr     (ovf_clr),
      .irq_ack     (irq_ack),
      .eoi         (eoi),
      .eoi_id      (eoi_id),
      .mask_q      (mask_q),
      .pending_q   (pending_q),
      .overflow_q  (overflow_q),
      .irq_req     (irq_req),
      .irq_id      (irq_id),
      .insvc_valid (insvc_valid),
      .insvc_id    (insvc_id)
   );

   // ---------------- scoreboard ----------------
   int   n_cmp = 0;
   int   n_err = 0;
   vec_t vecs[$];

   task automatic chk(input string name, input int idx,
                      input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got 0x%02h expected 0x%02h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic rn, input logic [7:0] pl, input logic we, input logic [7:0] wd,
      input logic [7:0] ps, input logic [7:0] pc, input logic [7:0] oc,
      input logic ak, input logic eo, input logic [2:0] ei,
      input logic [7:0] em, input logic [7:0] ep, input logic [7:0] eov,
      input logic er, input logic [2:0] eid_o, input logic eiv, input logic [2:0] eii);
      vec_t v;
      v.rst_n = rn;  v.pulse = pl; v.mwe = we;   v.mwd = wd;
      v.pset  = ps;  v.pclr  = pc; v.oclr = oc;  v.ack = ak;
      v.eoi   = eo;  v.eid   = ei;
      v.e_mask = em; v.e_pend = ep; v.e_ovf = eov; v.e_req = er;
      v.e_id   = eid_o; v.e_iv = eiv; v.e_iid = eii;
      return v;
   endfunction

   // ---------------- driver ----------------
   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      rst_n      = v.rst_n;
      src_pulse  = v.pulse;
      mask_we    = v.mwe;
      mask_wdata = v.mwd;
      pend_set   = v.pset;
      pend_clr   = v.pclr;
      ovf_clr    = v.oclr;
      irq_ack    = v.ack;
      eoi        = v.eoi;
      eoi_id     = v.eid;
      @(posedge clk);
      #1;
      chk("mask_q",      idx, mask_q,             v.e_mask);
      chk("pending_q",   idx, pending_q,          v.e_pend);
      chk("overflow_q",  idx, overflow_q,         v.e_ovf);
      chk("irq_req",     idx, {7'd0, irq_req},    {7'd0, v.e_req});
      chk("irq_id",      idx, {5'd0, irq_id},     {5'd0, v.e_id});
      chk("insvc_valid", idx, {7'd0, insvc_valid}, {7'd0, v.e_iv});
      chk("insvc_id",    idx, {5'd0, insvc_id},   {5'd0, v.e_iid});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      //            rst  pulse  we wdata  pset   pclr   oclr  ack eoi eid | mask   pend   ovf  req id iv iid
      // reset with pulses toggling; mask write ignored in reset
      vecs.push_back(mk(0, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h55, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      // single event on src 3
      vecs.push_back(mk(1, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h08, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'h08, 8'h00, 1, 3, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 1, 3));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 3, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0));
      // priority and no nesting
      vecs.push_back(mk(1, 8'h24, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'h24, 8'h00, 1, 2, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h20, 8'h00, 0, 0, 1, 2));
      vecs.push_back(mk(1, 8'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'h21, 8'h00, 0, 0, 1, 2));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h21, 8'h00, 0, 0, 1, 2));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 5, 8'hFF, 8'h21, 8'h00, 0, 0, 1, 2));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 2, 8'hFF, 8'h21, 8'h00, 1, 0, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h20, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 8'h20, 8'h00, 1, 5, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 1, 5));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 5, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0));
      // masking
      vecs.push_back(mk(1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h02, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h02, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h00, 1, 8'h02, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h02, 8'h00, 1, 1, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00, 8'h00, 0, 0, 1, 1));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'h02, 8'h00, 8'h00, 0, 0, 0, 0));
      // ack with nothing requested, eoi in idle: both ignored
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0, 8'h02, 8'h00, 8'h00, 0, 0, 0, 0));
      // overflow on masked src 4
      vecs.push_back(mk(1, 8'h10, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h10, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h10, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h10, 8'h10, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h10, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 0, 8'h02, 8'h10, 8'h10, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 0, 8'h02, 8'h10, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h10, 8'h00, 0, 0, 0, 8'h02, 8'h00, 8'h00, 0, 0, 0, 0));
      // collisions
      vecs.push_back(mk(1, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h01, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 0, 8'hFF, 8'h01, 8'h00, 1, 0, 0, 0));
      vecs.push_back(mk(1, 8'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h01, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 4, 8'hFF, 8'h01, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h80, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'h81, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'h81, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 8'h81, 8'h00, 1, 0, 0, 0));
      // reset mid-service drops the pulse of the reset cycle
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h80, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 8'h02, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i);
      end

      // Hand sequence: acknowledging src 2 while src 3 (already pending) and
      // src 2 both pulse. Only src 3 loses an event.
      apply(mk(1, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0), 100);
      apply(mk(1, 8'h0C, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'h0C, 8'h00, 1, 2, 0, 0), 101);
      apply(mk(1, 8'h0C, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h0C, 8'h08, 0, 0, 1, 2), 102);
      // Mask drop while in service: service state untouched, eoi then shows
      // nothing because everything is masked.
      apply(mk(1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h0C, 8'h08, 0, 0, 1, 2), 103);
      apply(mk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 2, 8'h00, 8'h0C, 8'h08, 0, 0, 0, 0), 104);
      // Unmask only src 3; clear pending 2 and set it again in the same cycle.
      apply(mk(1, 8'h00, 1, 8'h08, 8'h04, 8'h04, 8'h08, 0, 0, 0, 8'h08, 8'h0C, 8'h00, 1, 3, 0, 0), 105);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
